// File: rtl/core_pkg.sv
// Shared encodings for multicycle_core: opcodes, FSM states, ALU controls, immediate formats.
// Optional retire counter in the core is enabled by defining MULTICYCLE_RETIRE_CNT_EN.
package core_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_fmt_t;

  function automatic logic [31:0] imm32(input logic [31:0] ir, input imm_fmt_t fmt);
    case (fmt)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_J:   return {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational reads, one synchronous write, x0 hardwired to zero.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_waddr,
  input  logic [XLEN-1:0]          i_wdata,
  input  logic [$clog2(NREGS)-1:0] i_raddr1,
  input  logic [$clog2(NREGS)-1:0] i_raddr2,
  output logic [XLEN-1:0]          o_rdata1,
  output logic [XLEN-1:0]          o_rdata2
);

  logic [XLEN-1:0] r_mem [NREGS];

  // Contents are deliberately not reset; a same-cycle read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != '0)) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV-style core on a single unified memory port (fetch/load/store share it).
// Define MULTICYCLE_RETIRE_CNT_EN to add the 64-bit 'retired' instruction counter output.
module multicycle_core
  import core_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              NREGS    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            trap,
  output logic [XLEN-1:0] pc_out
`ifdef MULTICYCLE_RETIRE_CNT_EN
  ,
  output logic [63:0]     retired
`endif
);

  localparam int AW = $clog2(NREGS);

  state_t          r_state, w_next;
  logic [XLEN-1:0] r_pc, r_oldpc, r_a, r_b, r_aluout, r_data, r_target;
  logic [31:0]     r_ir;

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  imm_fmt_t        w_fmt;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data, w_alu_b, w_alu_y, w_rf_wdata, w_mem_addr;
  alu_t            w_alu_op;
  logic            w_rf_we, w_mem_req, w_mem_we, w_f3_alu_ok, w_r_ok;

  assign w_op = r_ir[6:0];
  assign w_f3 = r_ir[14:12];
  assign w_f7 = r_ir[31:25];

  always_comb begin
    w_fmt = IMM_I;
    case (w_op)
      OP_STORE:  w_fmt = IMM_S;
      OP_BRANCH: w_fmt = IMM_B;
      OP_JAL:    w_fmt = IMM_J;
      default:   w_fmt = IMM_I;
    endcase
  end

  assign w_imm32 = imm32(r_ir, w_fmt);
  assign w_imm   = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};

  assign w_f3_alu_ok = (w_f3 == F3_ADD) || (w_f3 == F3_SLT) || (w_f3 == F3_OR) || (w_f3 == F3_AND);
  assign w_r_ok      = w_f3_alu_ok && ((w_f7 == F7_BASE) || ((w_f7 == F7_SUB) && (w_f3 == F3_ADD)));

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .i_we     (w_rf_we),
    .i_waddr  (r_ir[7 +: AW]),
    .i_wdata  (w_rf_wdata),
    .i_raddr1 (r_ir[15 +: AW]),
    .i_raddr2 (r_ir[20 +: AW]),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data)
  );

  // funct7 bits are immediate bits for I-type, so only EXECR may select SUB.
  always_comb begin
    w_alu_op = ALU_ADD;
    if (r_state == EXECR || r_state == EXECI) begin
      case (w_f3)
        F3_SLT:  w_alu_op = ALU_SLT;
        F3_OR:   w_alu_op = ALU_OR;
        F3_AND:  w_alu_op = ALU_AND;
        default: w_alu_op = (r_state == EXECR && w_f7[5]) ? ALU_SUB : ALU_ADD;
      endcase
    end
  end

  assign w_alu_b = (r_state == EXECR) ? r_b : w_imm;

  always_comb begin
    w_alu_y = r_a + w_alu_b;
    case (w_alu_op)
      ALU_SUB: w_alu_y = r_a - w_alu_b;
      ALU_AND: w_alu_y = r_a & w_alu_b;
      ALU_OR:  w_alu_y = r_a | w_alu_b;
      ALU_SLT: w_alu_y = {{(XLEN-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_y = r_a + w_alu_b;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_rf_we    = 1'b0;
    w_rf_wdata = r_aluout;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = r_pc;
    case (r_state)
      FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        case (w_op)
          OP_LOAD, OP_STORE: w_next = (w_f3 == F3_WORD) ? MEMADR : TRAP;
          OP_REG:            w_next = w_r_ok ? EXECR : TRAP;
          OP_IMM:            w_next = w_f3_alu_ok ? EXECI : TRAP;
          OP_BRANCH:         w_next = (w_f3 == F3_BEQ) ? BEQ : TRAP;
          OP_JAL:            w_next = JAL;
          default:           w_next = TRAP;
        endcase
      end
      MEMADR: w_next = (w_op == OP_LOAD) ? MEMRD : MEMWR;
      MEMRD: begin
        w_mem_req  = 1'b1;
        w_mem_addr = r_aluout;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_data;
        w_next     = FETCH;
      end
      MEMWR: begin
        w_mem_req  = 1'b1;
        w_mem_we   = 1'b1;
        w_mem_addr = r_aluout;
        if (mem_ready) w_next = FETCH;
      end
      EXECR, EXECI: w_next = ALUWB;
      ALUWB: begin
        w_rf_we = 1'b1;
        w_next  = FETCH;
      end
      BEQ: w_next = FETCH;
      JAL: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = r_oldpc + XLEN'(4);
        w_next     = FETCH;
      end
      TRAP:    w_next = TRAP;
      default: w_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_oldpc  <= '0;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      r_data   <= '0;
      r_target <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata[31:0];
          r_oldpc <= r_pc;
          r_pc    <= r_pc + XLEN'(4);
        end
        DECODE: begin
          r_a      <= w_rs1_data;
          r_b      <= w_rs2_data;
          r_target <= r_oldpc + w_imm;
        end
        MEMADR, EXECR, EXECI: r_aluout <= w_alu_y;
        MEMRD: if (mem_ready) r_data <= mem_rdata;
        BEQ:   if (r_a == r_b) r_pc <= r_target;
        JAL:   r_pc <= r_target;
        default: ;
      endcase
    end
  end

  // Reset gates the request combinationally so an in-flight access is abandoned at once.
  assign mem_req   = w_mem_req & rst;
  assign mem_we    = w_mem_we & rst;
  assign mem_addr  = w_mem_addr;
  assign mem_wdata = r_b;
  assign trap      = (r_state == TRAP);
  assign pc_out    = r_pc;

`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic        w_retire;
  logic [63:0] r_retired;

  assign w_retire = (r_state == MEMWB) || (r_state == ALUWB) || (r_state == BEQ) ||
                    (r_state == JAL) || ((r_state == MEMWR) && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 64'd1;
  end

  assign retired = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: word memory model with programmable wait states, store scoreboard,
// table-driven ALU vectors plus hand sequences for reset, waits, branches, trap and mid-access reset.
module tb_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  multicycle_core #(.XLEN(32), .RESET_PC(32'h0), .NREGS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .trap      (trap),
    .pc_out    (pc_out)
`ifdef MULTICYCLE_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  string tag = "init";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {logic [31:0] addr; logic [31:0] data;} st_t;
  typedef struct {int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; int len;} tr_t;
  st_t exp_st[$];
  tr_t trace[$];

  logic [31:0] mem [1024];
  int cyc = 0;
  int waits = 0;
  int wcnt = 0;
  logic [31:0] h_addr, h_wdata;
  logic h_we;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: completes after 'waits' stall cycles, checks request stability while stalled.
  always @(negedge clk) begin
    st_t e;
    if (!rst || !mem_req) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
      end else begin
        chk({tag, "_hold_addr_data"}, {mem_addr, mem_wdata}, {h_addr, h_wdata});
        chk({tag, "_hold_we"}, 64'(mem_we), 64'(h_we));
      end
      if (wcnt < waits) begin
        mem_ready = 1'b0;
        wcnt++;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[11:2]];
        trace.push_back('{cyc, mem_addr, mem_we, mem_wdata, wcnt + 1});
        if (mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          if (exp_st.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s_store unexpected addr=%0h data=%0h", tag, mem_addr, mem_wdata);
          end else begin
            e = exp_st.pop_front();
            chk({tag, "_store"}, {mem_addr, mem_wdata}, {e.addr, e.data});
          end
        end
        wcnt = 0;
      end
    end
  end

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
  endfunction
  function automatic logic [31:0] lw(input int rd, input int off);
    return enc_i(off, 0, 3'b010, rd, 7'b0000011);
  endfunction

  task automatic reset_on(input string t);
    @(negedge clk);
    #1 rst = 1'b0;
    tag = t;
    exp_st.delete();
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic release_rst(input int w);
    waits = w;
    @(negedge clk);
    trace.delete();
    #2 rst = 1'b1;
  endtask

  task automatic wait_trap(input int bound);
    int n = 0;
    while (!trap && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_reach_trap"}, 64'(trap), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_st.size()), 64'd0);
  endtask

  typedef struct {logic [31:0] instr; logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;
  vec_t vt[14];

  logic [31:0] exp_fetch[10];
  int          exp_lat[9];

  initial begin : main
    int nf, found, n;
    logic [31:0] fa[$];
    int fc[$];

    vt[0]  = '{enc_r(7'h00, 2, 1, 3'b000, 3), 32'd5,         32'hFFFF_FFFD, 32'd2};
    vt[1]  = '{enc_r(7'h00, 2, 1, 3'b000, 3), 32'hFFFF_FFFF, 32'd1,         32'd0};
    vt[2]  = '{enc_r(7'h20, 2, 1, 3'b000, 3), 32'd3,         32'd5,         32'hFFFF_FFFE};
    vt[3]  = '{enc_r(7'h00, 2, 1, 3'b111, 3), 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
    vt[4]  = '{enc_r(7'h00, 2, 1, 3'b110, 3), 32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vt[5]  = '{enc_r(7'h00, 2, 1, 3'b010, 3), 32'hFFFF_FFFD, 32'd5,         32'd1};
    vt[6]  = '{enc_r(7'h00, 2, 1, 3'b010, 3), 32'd5,         32'hFFFF_FFFD, 32'd0};
    vt[7]  = '{enc_r(7'h00, 2, 1, 3'b010, 3), 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
    vt[8]  = '{addi(3, 1, -1),                           32'd10,        32'd0, 32'd9};
    vt[9]  = '{enc_i(32'h7FF, 1, 3'b111, 3, 7'b0010011), 32'hFFFF_FFFF, 32'd0, 32'h0000_07FF};
    vt[10] = '{enc_i(-2048, 1, 3'b110, 3, 7'b0010011),   32'h0000_0123, 32'd0, 32'hFFFF_F923};
    vt[11] = '{enc_i(-1, 1, 3'b010, 3, 7'b0010011),      32'hFFFF_FFFE, 32'd0, 32'd1};
    vt[12] = '{enc_i(5, 1, 3'b010, 3, 7'b0010011),       32'd5,         32'd0, 32'd0};
    vt[13] = '{enc_r(7'h20, 2, 1, 3'b000, 3), 32'd0,         32'd1,         32'hFFFF_FFFF};

    exp_fetch = '{32'h00, 32'h04, 32'h20, 32'h18, 32'h30, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    exp_lat   = '{4, 3, 3, 3, 3, 4, 3, 5, 4};

    // Reset state, first fetch, sticky trap and its clear.
    reset_on("reset");
    mem[0] = addi(1, 0, 1);
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_trap", 64'(trap), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'h0);
    release_rst(0);
    @(negedge clk);
    chk("first_req", {31'd0, mem_req, 31'd0, mem_we}, {31'd0, 1'b1, 31'd0, 1'b0});
    chk("first_addr", 64'(mem_addr), 64'h0);
    @(negedge clk);
    chk("pc_after_fetch", 64'(pc_out), 64'h4);
    wait_trap(100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("trap_sticky", {63'd0, trap}, 64'd1);
      chk("trap_no_req", {63'd0, mem_req}, 64'd0);
    end
    #1 rst = 1'b0;
    #1 chk("trap_clear", 64'(trap), 64'd0);

    // ALU vectors: operands loaded from memory, result stored back for comparison.
    foreach (vt[i]) begin
      reset_on($sformatf("vec%0d", i));
      mem[0] = lw(1, 32'h100);
      mem[1] = lw(2, 32'h104);
      mem[2] = vt[i].instr;
      mem[3] = enc_s(32'h108, 3, 0);
      mem[32'h40] = vt[i].a;
      mem[32'h41] = vt[i].b;
      exp_st.push_back('{32'h108, vt[i].exp});
      release_rst(i % 4);
      wait_trap(400);
    end

    // Immediates, signed compare, and x0 write discard.
    reset_on("alu_seq");
    mem[0] = addi(1, 0, 5);
    mem[1] = addi(2, 0, -3);
    mem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
    mem[3] = enc_r(7'h00, 1, 2, 3'b010, 4);
    mem[4] = addi(0, 0, 7);
    mem[5] = enc_s(32'h200, 3, 0);
    mem[6] = enc_s(32'h204, 4, 0);
    mem[7] = enc_s(32'h208, 0, 0);
    exp_st.push_back('{32'h200, 32'd2});
    exp_st.push_back('{32'h204, 32'd1});
    exp_st.push_back('{32'h208, 32'd0});
    release_rst(0);
    wait_trap(200);

    // Store then load at address 8 with 3 wait cycles per access.
    reset_on("waits");
    mem[0]     = addi(3, 0, 2);
    mem[1]     = enc_j(32'h40, 0);
    mem[32'h11] = enc_s(8, 3, 0);
    mem[32'h12] = lw(5, 8);
    mem[32'h13] = enc_s(32'h210, 5, 0);
    exp_st.push_back('{32'h008, 32'd2});
    exp_st.push_back('{32'h210, 32'd2});
    release_rst(3);
    wait_trap(300);
    found = 0;
    foreach (trace[i]) if (trace[i].addr == 32'h8) begin
      found++;
      chk("waits_hold_len", 64'(trace[i].len), 64'd4);
    end
    chk("waits_data_accesses", 64'(found), 64'd2);

    // Branch/jump targets and per-instruction latency from fetch-to-fetch spacing.
    reset_on("branch");
    mem[0]      = addi(1, 0, 1);
    mem[1]      = enc_j(32'h1C, 0);
    mem[32'h08] = enc_b(-8, 1, 1);
    mem[32'h06] = enc_j(32'h18, 0);
    mem[32'h0C] = enc_j(16, 6);
    mem[32'h10] = enc_s(32'h200, 6, 0);
    mem[32'h11] = enc_b(8, 0, 1);
    mem[32'h12] = lw(7, 32'h200);
    mem[32'h13] = enc_s(32'h204, 7, 0);
    exp_st.push_back('{32'h200, 32'h34});
    exp_st.push_back('{32'h204, 32'h34});
    release_rst(0);
    wait_trap(200);
    foreach (trace[i]) if (!trace[i].we && trace[i].addr < 32'h100) begin
      fa.push_back(trace[i].addr);
      fc.push_back(trace[i].cyc);
    end
    nf = fa.size();
    chk("branch_fetch_count", 64'(nf), 64'd10);
    if (nf == 10) begin
      for (int i = 0; i < 10; i++) chk($sformatf("branch_fetch%0d", i), 64'(fa[i]), 64'(exp_fetch[i]));
      for (int i = 0; i < 9; i++) chk($sformatf("latency%0d", i), 64'(fc[i+1] - fc[i]), 64'(exp_lat[i]));
    end
`ifdef MULTICYCLE_RETIRE_CNT_EN
    chk("retired", retired, 64'd9);
`endif

    // Illegal funct7 on an R-type traps right after its fetch.
    reset_on("bad_funct");
    mem[0] = enc_r(7'h01, 2, 1, 3'b000, 3);
    release_rst(0);
    wait_trap(50);
    chk("bad_funct_fetches", 64'(trace.size()), 64'd1);

    // Reset during a load wait: request drops at once and the load never writes x5.
    reset_on("midrst");
    mem[0]      = addi(5, 0, 32'h55);
    mem[1]      = lw(5, 32'h100);
    mem[32'h40] = 32'hDEAD;
    release_rst(6);
    n = 0;
    while (!(mem_req && mem_addr == 32'h100) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_reach_load", 64'(mem_req && mem_addr == 32'h100), 64'd1);
    #2 rst = 1'b0;
    #1 chk("midrst_req_drop", 64'(mem_req), 64'd0);
    chk("midrst_pc", 64'(pc_out), 64'h0);
    for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
    mem[0] = enc_s(32'h300, 5, 0);
    exp_st.push_back('{32'h300, 32'h55});
    release_rst(0);
    wait_trap(100);
    if (trace.size() > 0) chk("midrst_first_fetch", {trace[0].addr, 31'd0, trace[0].we}, {32'h0, 32'h0});
    else begin
      checks++; errors++;
      $display("FAIL midrst_first_fetch actual=none expected=0");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 and 64.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter NREGS, default 32, architectural register count; legal values 16 and 32.
REQ-004 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port mem_req  output  1  memory transaction request.
REQ-007 Port mem_we  output  1  1 = store, 0 = load/fetch; valid only while mem_req is high.
REQ-008 Port mem_addr  output  XLEN  byte address.
REQ-009 Port mem_wdata  output  XLEN  store data.
REQ-010 Port mem_rdata  input  XLEN  load/fetch data; sampled on the completing cycle.
REQ-011 Port mem_ready  input  1  transaction completes on any cycle where mem_req && mem_ready.
REQ-012 Port trap  output  1  sticky illegal-instruction indicator.
REQ-013 Port pc_out  output  XLEN  current PC, for test.

Function
REQ-014 Single unified memory port; fetch, load and store share it, one transaction at a time.
REQ-015 While mem_req is high, mem_addr, mem_we and mem_wdata SHALL hold stable until completion; mem_req SHALL NOT drop before mem_ready.
REQ-016 Supported instructions: lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal; slt/slti compare signed.
REQ-017 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP.
REQ-018 FETCH: request mem_addr = PC; on completion latch IR <= mem_rdata[31:0], OLDPC <= PC, PC <= PC+4, then go to DECODE. Wait states repeat FETCH.
REQ-019 DECODE: latch A = rs1 and B = rs2; compute TARGET = OLDPC + sign-extended immediate; dispatch on opcode. Unknown opcode or funct goes to TRAP.
REQ-020 MEMADR: ALUOUT = A + imm. lw goes to MEMRD; sw goes to MEMWR.
REQ-021 MEMRD waits for completion and latches DATA; then MEMWB writes rd <= DATA; then FETCH.
REQ-022 MEMWR requests with mem_we = 1 and mem_wdata = B; on completion goes to FETCH.
REQ-023 EXECR and EXECI compute ALUOUT; ALUWB writes rd; then FETCH.
REQ-024 BEQ: if A == B, PC <= TARGET; then FETCH.
REQ-025 JAL: rd <= OLDPC+4 and PC <= TARGET in the same cycle; then FETCH.
REQ-026 Writes to x0 are discarded; reads of x0 return 0. A write and a read of the same register in one cycle return the old value.
REQ-027 Arithmetic wraps modulo 2^XLEN; PC wraps from all-ones+4 to 3 mod 2^XLEN without a trap.
REQ-028 TRAP: trap = 1, mem_req = 0, state held until reset.
REQ-029 For XLEN=64, lw/sw operate on the full XLEN word (no sub-word accesses).
REQ-030 Latencies with zero-wait memory: R/I = 4 cycles, beq = 3, jal = 3, lw = 5, sw = 4; each memory wait cycle adds 1.

Reset
REQ-031 When rst is low, asynchronously: state = FETCH, PC = RESET_PC, IR/A/B/ALUOUT/DATA = 0, trap = 0, mem_req = 0, mem_we = 0. The register file is not reset.
REQ-032 Reset asserted mid-transaction drops mem_req in the same cycle and abandons the access; the first request after release is a fetch from RESET_PC.

Configuration
REQ-033 Macro MULTICYCLE_RETIRE_CNT_EN: when defined, adds output retired (64-bit), reset to 0, incremented by 1 on each instruction's final-state cycle (not TRAP), wrapping at 2^64; when undefined, the port and the counter are absent.

Structure
REQ-034 Package core_pkg SHALL hold: opcode constants, the FSM state enum, ALU control encodings, and immediate-format encodings.
REQ-035 One sub-module, regfile_2r1w (parameters XLEN and NREGS; 2 combinational read ports, 1 synchronous write port).

Verification
REQ-036 Reset release, zero-wait memory: first mem_addr = RESET_PC, mem_we = 0 -> pc_out = RESET_PC+4 after the fetch completes.
REQ-037 addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; slt x4,x2,x1 -> x3 = 2, x4 = 1.
REQ-038 sw x3,8(x0) then lw x5,8(x0) with 3 wait cycles per access -> store at addr 8 with data 2; x5 = 2; request held stable for 4 cycles each.
REQ-039 beq x1,x1,-8 at PC 0x20 -> next fetch at 0x18; jal x6,+16 at 0x30 -> x6 = 0x34, next fetch at 0x40.
REQ-040 Fetch returns 0xFFFFFFFF -> trap = 1, mem_req stays 0; rst low clears trap.
REQ-041 rst asserted during a MEMRD wait -> mem_req = 0 immediately; no register write occurs.
